// File: rtl/mem_stage_ctrl_pkg.sv
// Shared M-stage definitions: access FSM encoding, M/WB bubble values and
// the word-alignment helper used by the data-memory controller.
package mem_stage_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    localparam logic       BUBBLE_REG_WR     = 1'b0;
    localparam logic       BUBBLE_MEM_TO_REG = 1'b0;
    localparam logic [1:0] WORD_ALIGN_MASK   = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & WORD_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_mem_wb.sv
// M/WB pipeline register. A bubble clears only the write-enable controls
// and leaves the data fields holding their previous contents.
module mem_wb_register
    import mem_stage_ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        Resetn,
    input  logic        bubble,
    input  logic        load_data,
    input  logic        RegWr_M,
    input  logic        MemtoReg_M,
    input  logic [4:0]  Rd_M,
    input  logic [31:0] ALUout_M,
    input  logic [31:0] mem_rdata,
    output logic        RegWr_W,
    output logic        MemtoReg_W,
    output logic [4:0]  Rd_W,
    output logic [31:0] ALUout_W,
    output logic [31:0] MemData_W
);

    logic        reg_wr_q,     reg_wr_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic [4:0]  rd_q,         rd_d;
    logic [31:0] alu_out_q,    alu_out_d;
    logic [31:0] mem_data_q,   mem_data_d;

    always_comb begin
        reg_wr_d     = reg_wr_q;
        mem_to_reg_d = mem_to_reg_q;
        rd_d         = rd_q;
        alu_out_d    = alu_out_q;
        mem_data_d   = mem_data_q;
        if (bubble) begin
            reg_wr_d     = BUBBLE_REG_WR;
            mem_to_reg_d = BUBBLE_MEM_TO_REG;
        end else begin
            reg_wr_d     = RegWr_M;
            mem_to_reg_d = MemtoReg_M;
            rd_d         = Rd_M;
            alu_out_d    = ALUout_M;
            // Load data is captured only when a load completes this cycle.
            if (load_data) begin
                mem_data_d = mem_rdata;
            end
        end
    end

    always_ff @(negedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            reg_wr_q     <= 1'b0;
            mem_to_reg_q <= 1'b0;
            rd_q         <= '0;
            alu_out_q    <= '0;
            mem_data_q   <= '0;
        end else begin
            reg_wr_q     <= reg_wr_d;
            mem_to_reg_q <= mem_to_reg_d;
            rd_q         <= rd_d;
            alu_out_q    <= alu_out_d;
            mem_data_q   <= mem_data_d;
        end
    end

    assign RegWr_W    = reg_wr_q;
    assign MemtoReg_W = mem_to_reg_q;
    assign Rd_W       = rd_q;
    assign ALUout_W   = alu_out_q;
    assign MemData_W  = mem_data_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// M-stage controller: single-outstanding data-memory access with timeout,
// upstream stall, sticky bus error, PC redirect and the M/WB register.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TCW     = 5
) (
    input  logic        CLK,
    input  logic        Resetn,
    input  logic        MemWr_M,
    input  logic        MemtoReg_M,
    input  logic        RegWr_M,
    input  logic        Branch_M,
    input  logic        Zero_M,
    input  logic        Jump_M,
    input  logic [31:0] ALUout_M,
    input  logic [31:0] busB_M,
    input  logic [31:0] Target_M,
    input  logic [4:0]  Rd_M,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        stall_M,
    output logic        PCSrc_M,
    output logic [31:0] PCTarget_M,
    output logic        bus_err,
    output logic        RegWr_W,
    output logic        MemtoReg_W,
    output logic [4:0]  Rd_W,
    output logic [31:0] ALUout_W,
    output logic [31:0] MemData_W
);

    localparam logic [TCW-1:0] TIMEOUT_CNT = TCW'(TIMEOUT);

    mem_state_e     state_q, state_d;
    logic [TCW-1:0] cnt_q,   cnt_d;
    logic           bus_err_q, bus_err_d;

    logic memop;
    logic misal;
    logic in_wait;
    logic timeout;
    logic abort;
    logic load_done;

    assign memop     = MemWr_M | MemtoReg_M;
    assign misal     = memop & is_misaligned(ALUout_M[1:0]);
    assign in_wait   = (state_q == WAIT);
    assign timeout   = in_wait & ~mem_ack & (cnt_q == TIMEOUT_CNT);
    assign abort     = (~in_wait & misal) | timeout;
    assign load_done = MemtoReg_M & mem_req & mem_ack;

    // Address and data come straight from EX/M, which the stall holds steady.
    assign mem_req    = in_wait | (memop & ~misal);
    assign mem_we     = MemWr_M;
    assign mem_addr   = ALUout_M;
    assign mem_wdata  = busB_M;
    assign stall_M    = mem_req & ~mem_ack & ~timeout;
    assign PCSrc_M    = ~stall_M & (Jump_M | (Branch_M & Zero_M));
    assign PCTarget_M = Target_M;
    assign bus_err    = bus_err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q | abort;
        case (state_q)
            IDLE: begin
                if (memop & ~misal & ~mem_ack) begin
                    state_d = WAIT;
                    cnt_d   = TCW'(1);
                end
            end
            WAIT: begin
                if (mem_ack | timeout) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + TCW'(1);
                end
            end
        endcase
    end

    always_ff @(negedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    mem_wb_register u_mem_wb (
        .CLK        (CLK),
        .Resetn     (Resetn),
        .bubble     (stall_M | abort),
        .load_data  (load_done),
        .RegWr_M    (RegWr_M),
        .MemtoReg_M (MemtoReg_M),
        .Rd_M       (Rd_M),
        .ALUout_M   (ALUout_M),
        .mem_rdata  (mem_rdata),
        .RegWr_W    (RegWr_W),
        .MemtoReg_W (MemtoReg_W),
        .Rd_W       (Rd_W),
        .ALUout_W   (ALUout_W),
        .MemData_W  (MemData_W)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: inputs change just after each negedge,
// combinational outputs are sampled at posedge, registers just after negedge.
module tb_mem_stage_ctrl;

    logic        CLK = 1'b1;
    logic        Resetn = 1'b1;
    logic        MemWr_M, MemtoReg_M, RegWr_M, Branch_M, Zero_M, Jump_M;
    logic [31:0] ALUout_M, busB_M, Target_M, mem_rdata;
    logic [4:0]  Rd_M;
    logic        mem_ack;
    logic        mem_req, mem_we, stall_M, PCSrc_M, bus_err;
    logic [31:0] mem_addr, mem_wdata, PCTarget_M;
    logic        RegWr_W, MemtoReg_W;
    logic [4:0]  Rd_W;
    logic [31:0] ALUout_W, MemData_W;

    int checks = 0;
    int errors = 0;
    int stall_cycles;
    int req_cycles;

    always #5 CLK = ~CLK;

    mem_stage_ctrl #(.TIMEOUT(16), .TCW(5)) dut (
        .CLK        (CLK),
        .Resetn     (Resetn),
        .MemWr_M    (MemWr_M),
        .MemtoReg_M (MemtoReg_M),
        .RegWr_M    (RegWr_M),
        .Branch_M   (Branch_M),
        .Zero_M     (Zero_M),
        .Jump_M     (Jump_M),
        .ALUout_M   (ALUout_M),
        .busB_M     (busB_M),
        .Target_M   (Target_M),
        .Rd_M       (Rd_M),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .stall_M    (stall_M),
        .PCSrc_M    (PCSrc_M),
        .PCTarget_M (PCTarget_M),
        .bus_err    (bus_err),
        .RegWr_W    (RegWr_W),
        .MemtoReg_W (MemtoReg_W),
        .Rd_W       (Rd_W),
        .ALUout_W   (ALUout_W),
        .MemData_W  (MemData_W)
    );

    task automatic applyStimulus(input logic mem_wr, input logic mem_to_reg,
                                 input logic reg_wr, input logic branch,
                                 input logic zero, input logic jump,
                                 input logic [31:0] alu_out, input logic [31:0] bus_b,
                                 input logic [31:0] target, input logic [4:0] rd,
                                 input logic ack, input logic [31:0] rdata);
        MemWr_M    = mem_wr;
        MemtoReg_M = mem_to_reg;
        RegWr_M    = reg_wr;
        Branch_M   = branch;
        Zero_M     = zero;
        Jump_M     = jump;
        ALUout_M   = alu_out;
        busB_M     = bus_b;
        Target_M   = target;
        Rd_M       = rd;
        mem_ack    = ack;
        mem_rdata  = rdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(negedge CLK);
        #1;
    endtask

    task automatic midCycle();
        @(posedge CLK);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        #1 Resetn = 1'b0;
        #1;
        checkOutput("rst_req",     mem_req,   0);
        checkOutput("rst_stall",   stall_M,   0);
        checkOutput("rst_buserr",  bus_err,   0);
        checkOutput("rst_regwr",   RegWr_W,   0);
        checkOutput("rst_memdata", MemData_W, 0);
        nextCycle();
        Resetn = 1'b1;

        // Zero-wait load
        applyStimulus(0, 1, 1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 5'd7, 1, 32'hDEADBEEF);
        midCycle();
        checkOutput("ld0_req",   mem_req,  1);
        checkOutput("ld0_we",    mem_we,   0);
        checkOutput("ld0_addr",  mem_addr, 32'h10);
        checkOutput("ld0_stall", stall_M,  0);
        nextCycle();
        checkOutput("ld0_memdata", MemData_W,  32'hDEADBEEF);
        checkOutput("ld0_regwr",   RegWr_W,    1);
        checkOutput("ld0_memtoreg",MemtoReg_W, 1);
        checkOutput("ld0_rd",      Rd_W,       7);
        checkOutput("ld0_aluout",  ALUout_W,   32'h10);

        // Store acked after 3 cycles with a taken branch riding along
        applyStimulus(1, 0, 0, 1, 1, 0, 32'h20, 32'h12345678, 32'h400, 5'd3, 0, 32'h0);
        stall_cycles = 0;
        req_cycles   = 0;
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 3);
            midCycle();
            if (stall_M) stall_cycles++;
            if (mem_req) req_cycles++;
            checkOutput("st_we",     mem_we,     1);
            checkOutput("st_wdata",  mem_wdata,  32'h12345678);
            checkOutput("st_pcsrc",  PCSrc_M,    (i == 3) ? 32'd1 : 32'd0);
            checkOutput("st_target", PCTarget_M, 32'h400);
            nextCycle();
            checkOutput("st_regwr",  RegWr_W,    0);
            if (i < 3) checkOutput("st_rd_hold", Rd_W, 7);
        end
        checkOutput("st_req_cycles",   req_cycles,   4);
        checkOutput("st_stall_cycles", stall_cycles, 3);
        checkOutput("st_rd",       Rd_W,      3);
        checkOutput("st_aluout",   ALUout_W,  32'h20);
        checkOutput("st_memdata",  MemData_W, 32'hDEADBEEF);

        // Stray ack with no memory op, then a jump
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 1, 32'h0);
        midCycle();
        checkOutput("ack_ign_req",   mem_req, 0);
        checkOutput("ack_ign_stall", stall_M, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h800, 5'd0, 0, 32'h0);
        midCycle();
        checkOutput("jmp_pcsrc",  PCSrc_M,    1);
        checkOutput("jmp_target", PCTarget_M, 32'h800);
        nextCycle();

        // Load that never gets acked: 1 IDLE + 16 WAIT cycles
        applyStimulus(0, 1, 1, 0, 0, 0, 32'h40, 32'h0, 32'h0, 5'd5, 0, 32'h0);
        checkOutput("to_buserr_pre", bus_err, 0);
        stall_cycles = 0;
        for (int i = 0; i < 17; i++) begin
            midCycle();
            if (stall_M) stall_cycles++;
            checkOutput("to_req", mem_req, 1);
            nextCycle();
            checkOutput("to_regwr", RegWr_W, 0);
        end
        checkOutput("to_stall_cycles", stall_cycles, 16);
        checkOutput("to_buserr", bus_err, 1);
        checkOutput("to_rd_hold", Rd_W, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        midCycle();
        checkOutput("to_idle_req", mem_req, 0);
        nextCycle();
        checkOutput("to_buserr_sticky", bus_err, 1);

        // Reset asserted in the second WAIT cycle
        applyStimulus(0, 1, 1, 0, 0, 0, 32'h80, 32'h0, 32'h0, 5'd6, 0, 32'h0);
        nextCycle();
        nextCycle();
        midCycle();
        checkOutput("rw_req_before", mem_req, 1);
        Resetn = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        #1;
        checkOutput("rw_req",     mem_req,   0);
        checkOutput("rw_stall",   stall_M,   0);
        checkOutput("rw_buserr",  bus_err,   0);
        checkOutput("rw_regwr",   RegWr_W,   0);
        checkOutput("rw_rd",      Rd_W,      0);
        checkOutput("rw_aluout",  ALUout_W,  0);
        checkOutput("rw_memdata", MemData_W, 0);
        nextCycle();
        Resetn = 1'b1;
        applyStimulus(0, 1, 1, 0, 0, 0, 32'h24, 32'h0, 32'h0, 5'd10, 0, 32'hCAFEF00D);
        midCycle();
        checkOutput("rw_ld_stall0", stall_M, 1);
        nextCycle();
        mem_ack = 1'b1;
        midCycle();
        checkOutput("rw_ld_stall1", stall_M, 0);
        nextCycle();
        checkOutput("rw_ld_memdata", MemData_W, 32'hCAFEF00D);
        checkOutput("rw_ld_regwr",   RegWr_W,   1);
        checkOutput("rw_ld_rd",      Rd_W,      10);

        // ALU op, then a misaligned load
        applyStimulus(0, 0, 1, 0, 0, 0, 32'h55, 32'h0, 32'h0, 5'd9, 0, 32'h0);
        nextCycle();
        checkOutput("alu_regwr",  RegWr_W,  1);
        checkOutput("alu_aluout", ALUout_W, 32'h55);
        applyStimulus(0, 1, 1, 0, 0, 0, 32'h13, 32'h0, 32'h0, 5'd12, 0, 32'h0);
        midCycle();
        checkOutput("mis_req",        mem_req, 0);
        checkOutput("mis_stall",      stall_M, 0);
        checkOutput("mis_buserr_pre", bus_err, 0);
        nextCycle();
        checkOutput("mis_buserr", bus_err,  1);
        checkOutput("mis_regwr",  RegWr_W,  0);
        checkOutput("mis_rd",     Rd_W,     9);
        checkOutput("mis_aluout", ALUout_W, 32'h55);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        nextCycle();
        checkOutput("mis_buserr_sticky", bus_err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
